ptp_parser_mq: RTL and testbench

Parametrised PTP frame parser with a queued information output. It sits in the TSU after the MAC-side 32-bit packet interface and in parallel with timestamp capture. It decodes Ethernet/VLAN/MPLS/IPv4/IPv6/UDP encapsulations to locate PTP headers. Qualifying messages (by version and message-type mask) are reported through a valid/ready FIFO, with saturating overflow accounting.

---
 rtl/ptp_parser_mq.sv | 233 +++++++++++++++++++++++
 tb/tb_ptp_parser_mq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ptp_parser_mq.sv
// Walks Ethernet/VLAN/MPLS/IPv4/IPv6/UDP headers to PTP and queues qualifying records.
// Record visible 2 edges after PTP word 7; a full queue without a same-cycle pop drops into a saturating counter.
module ptp_parser_mq #(
  parameter int          MAX_VLAN     = 2,
  parameter int          MAX_MPLS     = 3,
  parameter bit          EN_IPV6      = 1'b1,
  parameter logic [15:0] UDP_PORT_EVT = 16'd319,
  parameter logic [15:0] UDP_PORT_GEN = 16'd320,
  parameter logic [15:0] EVT_MASK     = 16'h000F,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   int_data,
  input  logic                          int_valid,
  input  logic                          int_sop,
  input  logic                          int_eop,
  input  logic [1:0]                    int_mod,
  output logic                          ptp_valid,
  input  logic                          ptp_ready,
  output logic [31:0]                   ptp_infor,
  output logic [1:0]                    ptp_encap,
  output logic [7:0]                    ptp_domain,
  output logic [$clog2(FIFO_DEPTH):0]   ptp_level,
  output logic [15:0]                   ptp_ovf_cnt
);
  typedef enum logic [2:0] {ETH, VLAN, MPLS, IPV4, IPV6, UDP, PTP, SKIP} state_t;
  typedef struct packed {
    logic [31:0] infor;
    logic [1:0]  encap;
    logic [7:0]  domain;
  } rec_t;

  state_t      state, state_cur, state_nxt;
  logic [2:0]  w, w_cur, w_nxt;
  logic [3:0]  sub, sub_cur, sub_nxt;
  logic [2:0]  vlan_cnt, vlan_cur, vlan_nxt;
  logic [3:0]  mpls_cnt, mpls_cur, mpls_nxt;
  logic        bos, bos_cur, bos_nxt;
  logic [1:0]  encap, encap_cur, encap_nxt;
  logic        proto_ok, proto_nxt;
  logic [3:0]  msg_type, type_nxt, version, ver_nxt;
  logic [7:0]  domain, dom_nxt;
  logic [11:0] cksum, cksum_nxt;
  logic [15:0] prev_lo;
  logic [31:0] a;
  logic        hdr0_done, commit;
  rec_t        rec_q, rec_nxt, head;
  logic        rec_vld, fifo_in_rdy;
  logic        unused_mod;

  assign unused_mod = ^int_mod;
  assign a = {prev_lo, int_data[31:16]};

  function automatic state_t decode_etype(input logic [15:0] et, input logic [2:0] tags);
    state_t s;
    case (et)
      16'h8100, 16'h9100: s = (tags < 3'(MAX_VLAN)) ? VLAN : SKIP;
      16'h8847, 16'h8848: s = MPLS;
      16'h0800:           s = IPV4;
      16'h86DD:           s = EN_IPV6 ? IPV6 : SKIP;
      16'h88F7:           s = PTP;
      default:            s = SKIP;
    endcase
    return s;
  endfunction

  always_comb begin
    // A sop word restarts the parse regardless of where the previous packet stopped.
    state_cur = int_sop ? ETH   : state;
    w_cur     = int_sop ? 3'd0  : w;
    sub_cur   = int_sop ? 4'd0  : sub;
    vlan_cur  = int_sop ? 3'd0  : vlan_cnt;
    mpls_cur  = int_sop ? 4'd0  : mpls_cnt;
    bos_cur   = int_sop ? 1'b0  : bos;
    encap_cur = int_sop ? 2'd0  : encap;

    state_nxt = state_cur;
    w_nxt     = (w_cur == 3'd7) ? w_cur : w_cur + 3'd1;
    sub_nxt   = sub_cur + 4'd1;
    vlan_nxt  = vlan_cur;
    mpls_nxt  = mpls_cur;
    bos_nxt   = bos_cur;
    encap_nxt = encap_cur;
    proto_nxt = proto_ok;
    type_nxt  = msg_type;
    ver_nxt   = version;
    dom_nxt   = domain;
    cksum_nxt = cksum;
    rec_nxt   = rec_q;
    hdr0_done = 1'b0;
    commit    = 1'b0;

    case (state_cur)
      ETH:  if (w_cur == 3'd3) state_nxt = decode_etype(int_data[31:16], 3'd0);
      VLAN: begin
        vlan_nxt  = vlan_cur + 3'd1;
        state_nxt = decode_etype(int_data[31:16], vlan_cur + 3'd1);
      end
      MPLS: begin
        // The word after the bottom label is already IP header word 0.
        if (bos_cur) begin
          hdr0_done = 1'b1;
          if (a[31:24] == 8'h45)                 state_nxt = IPV4;
          else if (a[31:28] == 4'd6 && EN_IPV6)  state_nxt = IPV6;
          else                                   state_nxt = SKIP;
        end else begin
          mpls_nxt = mpls_cur + 4'd1;
          if (a[8])                                       bos_nxt   = 1'b1;
          else if (mpls_cur + 4'd1 >= 4'(MAX_MPLS))       state_nxt = SKIP;
        end
      end
      IPV4: begin
        if (sub_cur == 4'd0 && a[31:24] != 8'h45) state_nxt = SKIP;
        if (sub_cur == 4'd2) proto_nxt = (a[23:16] == 8'h11);
        if (sub_cur == 4'd4) state_nxt = proto_ok ? UDP : SKIP;
      end
      IPV6: begin
        if (sub_cur == 4'd1 && a[15:8] != 8'h11) state_nxt = SKIP;
        else if (sub_cur == 4'd9)                state_nxt = UDP;
      end
      UDP: begin
        if (sub_cur == 4'd0 && a[15:0] != UDP_PORT_EVT && a[15:0] != UDP_PORT_GEN) state_nxt = SKIP;
        else if (sub_cur == 4'd1) state_nxt = PTP;
      end
      PTP: begin
        case (sub_cur)
          4'd0: begin type_nxt = a[27:24]; ver_nxt = a[19:16]; cksum_nxt = 12'd0; end
          4'd1: dom_nxt = a[31:24];
          4'd5, 4'd6: cksum_nxt = cksum + {4'h0, a[31:24]} + {4'h0, a[23:16]}
                                        + {4'h0, a[15:8]} + {4'h0, a[7:0]};
          4'd7: begin
            cksum_nxt      = cksum + {4'h0, a[31:24]} + {4'h0, a[23:16]};
            state_nxt      = SKIP;
            commit         = (version == 4'd2) && EVT_MASK[msg_type];
            rec_nxt.infor  = {msg_type, cksum_nxt, a[15:0]};
            rec_nxt.encap  = encap_cur;
            rec_nxt.domain = domain;
          end
          default: ;
        endcase
      end
      default: ;
    endcase

    if (int_eop) state_nxt = SKIP;
    if (state_nxt != state_cur) sub_nxt = hdr0_done ? 4'd1 : 4'd0;
    if (state_nxt == IPV4 && state_cur != IPV4) encap_nxt = 2'd1;
    if (state_nxt == IPV6 && state_cur != IPV6) encap_nxt = 2'd2;
  end

  // w starts saturated so words arriving after reset are ignored until a sop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ETH;  w <= 3'd7;  sub <= '0;  vlan_cnt <= '0;  mpls_cnt <= '0;
      bos <= 1'b0;  encap <= '0;  proto_ok <= 1'b0;  msg_type <= '0;  version <= '0;
      domain <= '0;  cksum <= '0;  prev_lo <= '0;  rec_q <= '0;  rec_vld <= 1'b0;
      ptp_ovf_cnt <= '0;
    end else begin
      rec_vld <= int_valid && commit;
      if (int_valid) begin
        state <= state_nxt;  w <= w_nxt;  sub <= sub_nxt;  vlan_cnt <= vlan_nxt;
        mpls_cnt <= mpls_nxt;  bos <= bos_nxt;  encap <= encap_nxt;  proto_ok <= proto_nxt;
        msg_type <= type_nxt;  version <= ver_nxt;  domain <= dom_nxt;  cksum <= cksum_nxt;
        prev_lo <= int_data[15:0];  rec_q <= rec_nxt;
      end
      if (rec_vld && !fifo_in_rdy && ptp_ovf_cnt != 16'hFFFF) ptp_ovf_cnt <= ptp_ovf_cnt + 16'd1;
    end
  end

  ptp_fifo #(.WIDTH($bits(rec_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (rec_vld),
    .in_rdy  (fifo_in_rdy),
    .in_dat  (rec_q),
    .out_vld (ptp_valid),
    .out_rdy (ptp_ready),
    .out_dat (head),
    .level   (ptp_level)
  );

  assign ptp_infor  = head.infor;
  assign ptp_encap  = head.encap;
  assign ptp_domain = head.domain;
endmodule

// Generic first-word-fall-through FIFO; head visible the cycle after the write edge.
// Accepts a write when full if the head is popped on the same edge.
module ptp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_vld,
  output logic                     in_rdy,
  input  logic [WIDTH-1:0]         in_dat,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [WIDTH-1:0]         out_dat,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push, pop;

  assign out_vld = (level != '0);
  assign in_rdy  = (level != FULL_LVL) || out_rdy;
  assign push    = in_vld && in_rdy;
  assign pop     = out_vld && out_rdy;
  assign out_dat = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end
endmodule

// File: tb/tb_ptp_parser_mq.sv
// Directed frames with hand-computed records; a monitor pops the expected queue on every output handshake.
`timescale 1ns/1ps
module tb_ptp_parser_mq;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] int_data;
  logic        int_valid, int_sop, int_eop;
  logic [1:0]  int_mod;
  logic        ptp_valid, ptp_ready;
  logic [31:0] ptp_infor;
  logic [1:0]  ptp_encap;
  logic [7:0]  ptp_domain;
  logic [2:0]  ptp_level;
  logic [15:0] ptp_ovf_cnt;

  typedef struct packed {
    logic [31:0] infor;
    logic [1:0]  encap;
    logic [7:0]  domain;
  } rec_t;

  rec_t       exp_q[$];
  logic [7:0] fb[$];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  ptp_parser_mq #(
    .MAX_VLAN(2), .MAX_MPLS(3), .EN_IPV6(1'b1), .UDP_PORT_EVT(16'd319),
    .UDP_PORT_GEN(16'd320), .EVT_MASK(16'h000F), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .int_data(int_data), .int_valid(int_valid), .int_sop(int_sop),
    .int_eop(int_eop), .int_mod(int_mod), .ptp_valid(ptp_valid), .ptp_ready(ptp_ready),
    .ptp_infor(ptp_infor), .ptp_encap(ptp_encap), .ptp_domain(ptp_domain),
    .ptp_level(ptp_level), .ptp_ovf_cnt(ptp_ovf_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic rec_t mk(input logic [3:0] t, input logic [11:0] ck, input logic [15:0] seq,
                              input logic [1:0] enc, input logic [7:0] dom);
    rec_t r;
    r.infor  = {t, ck, seq};
    r.encap  = enc;
    r.domain = dom;
    return r;
  endfunction

  task automatic add(input logic [7:0] b); fb.push_back(b); endtask
  task automatic add16(input logic [15:0] v); add(v[15:8]); add(v[7:0]); endtask
  task automatic addn(input int n, input logic [7:0] b); for (int i = 0; i < n; i++) add(b); endtask

  task automatic eth(input logic [15:0] et);
    fb.delete();
    addn(6, 8'h02); addn(6, 8'h11); add16(et);
  endtask
  task automatic vlan(input logic [15:0] et); add16(16'h0064); add16(et); endtask
  task automatic mpls(input bit bos_bit);
    add(8'h00); add(8'h01); add(bos_bit ? 8'h01 : 8'h00); add(8'h40);
  endtask
  task automatic ipv4(input logic [7:0] vihl, input logic [7:0] proto);
    add(vihl); add(8'h00); add16(16'd62); add16(16'h0000); add16(16'h0000);
    add(8'h40); add(proto); add16(16'h0000); addn(8, 8'h0A);
  endtask
  task automatic ipv6(input logic [7:0] nh);
    add(8'h60); addn(3, 8'h00); add16(16'd42); add(nh); add(8'h40); addn(32, 8'hFE);
  endtask
  task automatic udp(input logic [15:0] dport);
    add16(16'd5000); add16(dport); add16(16'd42); add16(16'h0000);
  endtask
  task automatic ptp(input logic [3:0] t, input logic [3:0] ver, input logic [7:0] dom,
                     input logic [7:0] cb, input logic [15:0] port, input logic [15:0] seq);
    add({4'h0, t}); add({4'h0, ver}); add16(16'd44); add(dom); add(8'h00); add16(16'h0000);
    addn(12, 8'h00); addn(8, cb); add16(port); add16(seq); add(8'h00); add(8'h00);
  endtask

  // Drives words first..end (or up to lim words), one per negedge, optional idle gaps.
  task automatic send(input int first, input int lim, input bit do_eop, input bit gaps);
    int nw;
    nw = (fb.size() + 3) / 4;
    if (lim > 0 && lim < nw) nw = lim;
    for (int i = first; i < nw; i++) begin
      logic [31:0] d;
      for (int b = 0; b < 4; b++) d[31-8*b -: 8] = (4*i+b < fb.size()) ? fb[4*i+b] : 8'h00;
      @(negedge clk);
      int_data = d; int_valid = 1'b1; int_sop = (i == 0);
      int_eop = do_eop && (i == nw-1); int_mod = 2'd0;
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          int_valid = 1'b0; int_sop = 1'b0; int_eop = 1'b0; int_data = 32'hDEAD_BEEF;
        end
      end
    end
    @(negedge clk);
    int_valid = 1'b0; int_sop = 1'b0; int_eop = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, ptp_valid, 0);
    check({tag, "_infor"}, ptp_infor, 0);
    check({tag, "_encap"}, ptp_encap, 0);
    check({tag, "_domain"}, ptp_domain, 0);
    check({tag, "_level"}, ptp_level, 0);
    check({tag, "_ovf"}, ptp_ovf_cnt, 0);
  endtask

  initial begin : monitor
    rec_t e;
    forever begin
      @(negedge clk); #1;
      if (!rst && ptp_valid && ptp_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pop: got infor 0x%08h, required no record", ptp_infor);
        end else begin
          e = exp_q.pop_front();
          check("pop_infor", ptp_infor, e.infor);
          check("pop_encap", ptp_encap, e.encap);
          check("pop_domain", ptp_domain, e.domain);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst = 1'b1; int_data = '0; int_valid = 1'b0; int_sop = 1'b0; int_eop = 1'b0;
    int_mod = '0; ptp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    // L2 Sync: cksum = 8*0x01 + 0x00 + 0x01
    eth(16'h88F7); ptp(4'd0, 4'd2, 8'h00, 8'h01, 16'h0001, 16'h1234);
    exp_q.push_back(mk(4'd0, 12'h009, 16'h1234, 2'd0, 8'h00));
    send(0, 0, 1'b1, 1'b0);
    check("lat_edge1_valid", ptp_valid, 0);
    @(negedge clk);
    check("lat_edge2_valid", ptp_valid, 1);
    wait_drain("l2_drain");

    // Double VLAN + IPv4/UDP 319, Delay_Req, with idle gaps: cksum = 8*0x10 + 1
    eth(16'h8100); vlan(16'h8100); vlan(16'h0800); ipv4(8'h45, 8'h11); udp(16'd319);
    ptp(4'd1, 4'd2, 8'h05, 8'h10, 16'h0001, 16'hBEEF);
    exp_q.push_back(mk(4'd1, 12'h081, 16'hBEEF, 2'd1, 8'h05));
    send(0, 0, 1'b1, 1'b1);
    wait_drain("vlan2_drain");

    // Three tags exceed MAX_VLAN
    eth(16'h8100); vlan(16'h8100); vlan(16'h8100); vlan(16'h0800); ipv4(8'h45, 8'h11);
    udp(16'd319); ptp(4'd1, 4'd2, 8'h05, 8'h10, 16'h0001, 16'hBEEF);
    send(0, 0, 1'b1, 1'b0);

    // MPLS x2 + IPv6/UDP 320: Follow_Up masked out, then type 3 at maximum cksum 2550
    eth(16'h8847); mpls(1'b0); mpls(1'b1); ipv6(8'h11); udp(16'd320);
    ptp(4'd8, 4'd2, 8'h7A, 8'hFF, 16'hFFFF, 16'h0042);
    send(0, 0, 1'b1, 1'b0);
    eth(16'h8847); mpls(1'b0); mpls(1'b1); ipv6(8'h11); udp(16'd320);
    ptp(4'd3, 4'd2, 8'h7A, 8'hFF, 16'hFFFF, 16'h0042);
    exp_q.push_back(mk(4'd3, 12'h9F6, 16'h0042, 2'd2, 8'h7A));
    send(0, 0, 1'b1, 1'b0);
    wait_drain("mpls_drain");

    // Rejections: version 1, IHL 6, UDP port 1000, eop at PTP word 5
    eth(16'h88F7); ptp(4'd0, 4'd1, 8'h00, 8'h01, 16'h0001, 16'h1111);
    send(0, 0, 1'b1, 1'b0);
    eth(16'h0800); ipv4(8'h46, 8'h11); udp(16'd319); ptp(4'd0, 4'd2, 8'h00, 8'h01, 16'h0001, 16'h2222);
    send(0, 0, 1'b1, 1'b0);
    eth(16'h0800); ipv4(8'h45, 8'h11); udp(16'd1000); ptp(4'd0, 4'd2, 8'h00, 8'h01, 16'h0001, 16'h3333);
    send(0, 0, 1'b1, 1'b0);
    eth(16'h88F7); ptp(4'd0, 4'd2, 8'h00, 8'h01, 16'h0001, 16'h4444);
    send(0, 10, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check("reject_valid", ptp_valid, 0);
    check("reject_level", ptp_level, 0);
    check("reject_ovf", ptp_ovf_cnt, 0);

    // sop arrives where PTP word 3 would be; only the new packet reports
    eth(16'h88F7); ptp(4'd0, 4'd2, 8'h00, 8'h01, 16'h0001, 16'hDEAD);
    send(0, 7, 1'b0, 1'b0);
    eth(16'h88F7); ptp(4'd0, 4'd2, 8'h00, 8'h01, 16'h0001, 16'h5555);
    exp_q.push_back(mk(4'd0, 12'h009, 16'h5555, 2'd0, 8'h00));
    send(0, 0, 1'b1, 1'b0);
    wait_drain("sop_abort_drain");

    // Overflow: six Pdelay_Req with ready low; cksum = 8*0x02 + 0x03
    ptp_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      eth(16'h88F7); ptp(4'd2, 4'd2, 8'h00, 8'h02, 16'h0003, 16'(i));
      if (i <= 4) exp_q.push_back(mk(4'd2, 12'h013, 16'(i), 2'd0, 8'h00));
      send(0, 0, 1'b1, 1'b0);
    end
    repeat (4) @(negedge clk);
    check("ovf_level", ptp_level, 4);
    check("ovf_cnt", ptp_ovf_cnt, 2);
    check("ovf_valid", ptp_valid, 1);
    ptp_ready = 1'b1;
    wait_drain("ovf_drain");
    check("ovf_after_valid", ptp_valid, 0);
    check("ovf_after_level", ptp_level, 0);

    // Reset mid-frame with one record queued
    ptp_ready = 1'b0;
    eth(16'h88F7); ptp(4'd0, 4'd2, 8'h00, 8'h01, 16'h0001, 16'hAAAA);
    send(0, 0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check("prerst_level", ptp_level, 1);
    eth(16'h88F7); ptp(4'd0, 4'd2, 8'h00, 8'h01, 16'h0001, 16'hBBBB);
    send(0, 6, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("midrst");
    rst = 1'b0;
    send(6, 0, 1'b1, 1'b0);
    ptp_ready = 1'b1;
    eth(16'h88F7); ptp(4'd1, 4'd2, 8'h09, 8'h01, 16'h0001, 16'h0C0C);
    exp_q.push_back(mk(4'd1, 12'h009, 16'h0C0C, 2'd0, 8'h09));
    send(0, 0, 1'b1, 1'b0);
    wait_drain("postrst_drain");
    check("final_ovf", ptp_ovf_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
